pyrxaclbuf_ring: RTL and testbench
==================================

Name: pyrxaclbuf_ring

Overview:
- Parametrised N-slot receive ACL payload buffer. Successor to the two-slot ping-pong rx buffer controller.
- Sits between the link controller payload writer (lnctrl_*) and the baseband state machine reader (bsm_*).
- Good packets are committed into a ring of NBUF slots, and bsm drains them in arrival order.
- Adds occupancy count, full flag, sticky overflow with clear, flush, and per-slot length readback.

Parameters:
- NBUF, 4, number of payload slots; power of two, 2..16.
- AW, 8, word-address width inside one slot (2^AW words per slot).
- DW, 32, data word width.
- LW, 10, payload byte-length width; must satisfy LW <= AW+2.

Ports:
- clk_6M  in  1  system clock.
- rstz  in  1  asynchronous active-low reset.
- ms_tslot_p  in  1  slot-boundary pulse, master/slave already selected.
- pk_encode  in  1  high = TX slot; commit suppressed.
- dec_hecgood  in  1  header HEC passed.
- dec_crcgood  in  1  payload CRC passed.
- dec_pylenByte  in  LW  received payload length in bytes.
- lnctrl_addr  in  AW  write word address within the current write slot.
- lnctrl_din  in  DW  write data.
- lnctrl_we  in  1  write enable.
- lnctrl_cs  in  1  write chip select.
- bsm_addr  in  AW  read word address within the current read slot.
- bsm_cs  in  1  read chip select.
- bsm_valid_p  in  1  pulse: word at bsm_addr consumed.
- regi_ovf_clr  in  1  pulse: clear regi_aclrxovf.
- regi_flush  in  1  pulse: discard all stored packets.
- bsm_dout  out  DW  read data, registered.
- bsm_rxlen  out  LW  stored byte length of the current read slot.
- regi_aclrxbufempty  out  1  no committed packet.
- regi_aclrxbuffull  out  1  NBUF packets committed.
- regi_aclrxovf  out  1  sticky: a good packet was dropped.
- rxbuf_count  out  log2(NBUF)+1  committed packet count.

Behaviour:
- Reset is async on rstz low (clock clk_6M). Reset values:
  - wptr=0, rptr=0, count=0, all stored lengths=0.
  - bsm_dout=0, regi_aclrxbufempty=1, regi_aclrxbuffull=0, regi_aclrxovf=0.
  - Storage contents are not reset.
- Storage is an NBUF*2^AW x DW array.
  - Physical write address = {wptr, lnctrl_addr}; physical read address = {rptr, bsm_addr}.
- Write: when lnctrl_cs & lnctrl_we & !full, the word is written at the clock edge. While full, writes are ignored so unread data is protected.
- Read: when bsm_cs, bsm_dout is updated at the next edge with the word at {rptr,bsm_addr} (1-cycle latency). When !bsm_cs, bsm_dout holds its value.
- good = ms_tslot_p & !pk_encode & dec_hecgood & dec_crcgood.
  - good & !full: len[wptr] <= dec_pylenByte; wptr <= wptr+1 (wraps mod NBUF); count+1.
  - good & full: packet dropped; regi_aclrxovf <= 1; pointers unchanged.
- endaddr from L = len[rptr]:
  - L==0 -> endaddr=0.
  - L[1:0]==0 -> endaddr = L>>2 minus 1.
  - otherwise -> endaddr = L>>2.
  - Computed at AW width.
- read_endp = bsm_valid_p & (bsm_addr >= endaddr) & !empty. On read_endp: rptr <= rptr+1 (wraps); count-1.
- Same-cycle good (not full) and read_endp: both pointers advance, count unchanged.
- Same-cycle good while full and read_endp: the slot frees this cycle, but the packet is still dropped and ovf is set. The full test uses the registered count.
- regi_flush: rptr <= wptr, count <= 0. It has priority over good and read_endp in the same cycle; a coincident good is dropped without setting ovf. Lengths are retained.
- regi_aclrxovf: set has priority over regi_ovf_clr in the same cycle.
- Status decode:
  - empty = (count==0); full = (count==NBUF).
  - Both are registered, updated in the same edge as count.
  - bsm_rxlen = len[rptr] (combinational from registers).
- read_endp while empty is ignored; count never underflows.

Test Plan:
- Reset, then a good commit with len=27 and 7 words written: count=1, empty=0, rxlen=27, endaddr=6. Reading addr 0..6 with valid_p: read_endp at addr 6, count=0, empty=1.
- NBUF=4, five good commits with no reads: count=4, full=1 after the 4th. The 5th sets ovf=1, and lnctrl writes during full leave slot rptr data unchanged. regi_ovf_clr -> ovf=0.
- Lengths 4, 1, 0, 1023 in successive slots: endaddr = 0, 0, 0, 255 respectively. Each drained in commit order with matching bsm_rxlen.
- Commit coincident with read_endp at count=2: count stays 2, wptr and rptr both advance. Wrap from slot 3 to slot 0 is verified on data.
- pk_encode=1, or hecgood=0, or crcgood=0 at ms_tslot_p: no commit, count unchanged, ovf unchanged.
- count=3, then regi_flush coincident with a good packet: count=0, empty=1, ovf=0. rstz asserted mid-read: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pyrxaclbuf_ring.sv
// N-slot receive ACL payload ring buffer. The link controller writes words into the
// current write slot; good packets commit the slot and record their byte length. The
// baseband state machine drains committed slots in arrival order.
module pyrxaclbuf_ring #(
   parameter int unsigned NBUF = 4,
   parameter int unsigned AW   = 8,
   parameter int unsigned DW   = 32,
   parameter int unsigned LW   = 10
) (
   input  logic                    clk_6M,
   input  logic                    rstz,
   input  logic                    ms_tslot_p,
   input  logic                    pk_encode,
   input  logic                    dec_hecgood,
   input  logic                    dec_crcgood,
   input  logic [LW-1:0]           dec_pylenByte,
   input  logic [AW-1:0]           lnctrl_addr,
   input  logic [DW-1:0]           lnctrl_din,
   input  logic                    lnctrl_we,
   input  logic                    lnctrl_cs,
   input  logic [AW-1:0]           bsm_addr,
   input  logic                    bsm_cs,
   input  logic                    bsm_valid_p,
   input  logic                    regi_ovf_clr,
   input  logic                    regi_flush,
   output logic [DW-1:0]           bsm_dout,
   output logic [LW-1:0]           bsm_rxlen,
   output logic                    regi_aclrxbufempty,
   output logic                    regi_aclrxbuffull,
   output logic                    regi_aclrxovf,
   output logic [$clog2(NBUF):0]   rxbuf_count
);

   localparam int unsigned PW = $clog2(NBUF);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned MD = NBUF * (2 ** AW);

   logic [DW-1:0] mem_q [MD];
   logic [LW-1:0] len_q [NBUF];
   logic [LW-1:0] len_d [NBUF];

   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
   logic [DW-1:0] dout_q, dout_d;

   logic          good, commit, drop, read_endp, mem_we;
   logic [LW-1:0] cur_len, len_words;
   logic [AW-1:0] endaddr;

   assign good    = ms_tslot_p & ~pk_encode & dec_hecgood & dec_crcgood;
   // Full test uses the registered status, so a slot freed this cycle does not help.
   assign commit  = good & ~full_q;
   assign drop    = good & full_q;
   assign mem_we  = lnctrl_cs & lnctrl_we & ~full_q;
   assign cur_len = len_q[rptr_q];

   // Last word address of the current read slot, derived from its byte length.
   always_comb begin
      len_words = cur_len >> 2;
      if (cur_len == '0) begin
         endaddr = '0;
      end else if (cur_len[1:0] == 2'b00) begin
         endaddr = AW'(len_words) - AW'(1);
      end else begin
         endaddr = AW'(len_words);
      end
   end

   assign read_endp = bsm_valid_p & (bsm_addr >= endaddr) & ~empty_q;

   // Pointer, count, length and status next-state; flush overrides commit and drain.
   always_comb begin
      len_d   = len_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (regi_flush) begin
         rptr_d  = wptr_q;
         count_d = '0;
      end else begin
         if (commit) begin
            len_d[wptr_q] = dec_pylenByte;
            wptr_d        = wptr_q + PW'(1);
         end
         if (read_endp) begin
            rptr_d = rptr_q + PW'(1);
         end
         case ({commit, read_endp})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
      if (drop && !regi_flush) begin
         ovf_d = 1'b1;
      end else if (regi_ovf_clr) begin
         ovf_d = 1'b0;
      end
      empty_d = (count_d == '0);
      full_d  = (count_d == CW'(NBUF));
      dout_d  = bsm_cs ? mem_q[{rptr_q, bsm_addr}] : dout_q;
   end

   // Control and status registers.
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dout_q  <= '0;
         for (int i = 0; i < NBUF; i++) begin
            len_q[i] <= '0;
         end
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
         ovf_q   <= ovf_d;
         dout_q  <= dout_d;
         len_q   <= len_d;
      end
   end

   // Payload storage, deliberately not reset.
   always_ff @(posedge clk_6M) begin
      if (mem_we) begin
         mem_q[{wptr_q, lnctrl_addr}] <= lnctrl_din;
      end
   end

   assign bsm_dout           = dout_q;
   assign bsm_rxlen          = cur_len;
   assign regi_aclrxbufempty = empty_q;
   assign regi_aclrxbuffull  = full_q;
   assign regi_aclrxovf      = ovf_q;
   assign rxbuf_count        = count_q;

endmodule

// File: tb/tb_pyrxaclbuf_ring.sv
// Directed bench for pyrxaclbuf_ring with NBUF=4, AW=8, DW=32, LW=10.
module tb_pyrxaclbuf_ring;

   logic        clk_6M = 1'b0;
   logic        rstz = 1'b0;
   logic        ms_tslot_p = 1'b0, pk_encode = 1'b0, dec_hecgood = 1'b0, dec_crcgood = 1'b0;
   logic [9:0]  dec_pylenByte = '0;
   logic [7:0]  lnctrl_addr = '0;
   logic [31:0] lnctrl_din = '0;
   logic        lnctrl_we = 1'b0, lnctrl_cs = 1'b0;
   logic [7:0]  bsm_addr = '0;
   logic        bsm_cs = 1'b0, bsm_valid_p = 1'b0, regi_ovf_clr = 1'b0, regi_flush = 1'b0;
   logic [31:0] bsm_dout;
   logic [9:0]  bsm_rxlen;
   logic        regi_aclrxbufempty, regi_aclrxbuffull, regi_aclrxovf;
   logic [2:0]  rxbuf_count;

   int n_checks = 0;
   int n_fail = 0;

   pyrxaclbuf_ring #(.NBUF(4), .AW(8), .DW(32), .LW(10)) dut (
      .clk_6M             (clk_6M),
      .rstz               (rstz),
      .ms_tslot_p         (ms_tslot_p),
      .pk_encode          (pk_encode),
      .dec_hecgood        (dec_hecgood),
      .dec_crcgood        (dec_crcgood),
      .dec_pylenByte      (dec_pylenByte),
      .lnctrl_addr        (lnctrl_addr),
      .lnctrl_din         (lnctrl_din),
      .lnctrl_we          (lnctrl_we),
      .lnctrl_cs          (lnctrl_cs),
      .bsm_addr           (bsm_addr),
      .bsm_cs             (bsm_cs),
      .bsm_valid_p        (bsm_valid_p),
      .regi_ovf_clr       (regi_ovf_clr),
      .regi_flush         (regi_flush),
      .bsm_dout           (bsm_dout),
      .bsm_rxlen          (bsm_rxlen),
      .regi_aclrxbufempty (regi_aclrxbufempty),
      .regi_aclrxbuffull  (regi_aclrxbuffull),
      .regi_aclrxovf      (regi_aclrxovf),
      .rxbuf_count        (rxbuf_count)
   );

   always #5 clk_6M = ~clk_6M;

   task automatic tick();
      @(posedge clk_6M);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      lnctrl_cs = 1'b1; lnctrl_we = 1'b1; lnctrl_addr = a; lnctrl_din = d;
      tick();
      lnctrl_cs = 1'b0; lnctrl_we = 1'b0;
   endtask

   task automatic commit(input logic [9:0] len);
      ms_tslot_p = 1'b1; dec_hecgood = 1'b1; dec_crcgood = 1'b1; dec_pylenByte = len;
      tick();
      ms_tslot_p = 1'b0; dec_hecgood = 1'b0; dec_crcgood = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic v);
      bsm_cs = 1'b1; bsm_addr = a; bsm_valid_p = v;
      tick();
      bsm_cs = 1'b0; bsm_valid_p = 1'b0;
   endtask

   task automatic test_reset();
      n_checks++; if (rxbuf_count !== 3'd0) begin n_fail++;
         $display("FAIL reset_count got %0d exp 0", rxbuf_count); end
      n_checks++; if (regi_aclrxbufempty !== 1'b1) begin n_fail++;
         $display("FAIL reset_empty got %b exp 1", regi_aclrxbufempty); end
      n_checks++; if (regi_aclrxbuffull !== 1'b0) begin n_fail++;
         $display("FAIL reset_full got %b exp 0", regi_aclrxbuffull); end
      n_checks++; if (regi_aclrxovf !== 1'b0) begin n_fail++;
         $display("FAIL reset_ovf got %b exp 0", regi_aclrxovf); end
      n_checks++; if (bsm_dout !== 32'h0) begin n_fail++;
         $display("FAIL reset_dout got %h exp 0", bsm_dout); end
      n_checks++; if (bsm_rxlen !== 10'd0) begin n_fail++;
         $display("FAIL reset_rxlen got %0d exp 0", bsm_rxlen); end
   endtask

   task automatic test_single();
      for (int i = 0; i < 7; i++) wr(8'(i), 32'hA000_0000 + 32'(i));
      commit(10'd27);
      n_checks++; if (rxbuf_count !== 3'd1) begin n_fail++;
         $display("FAIL single_count got %0d exp 1", rxbuf_count); end
      n_checks++; if (regi_aclrxbufempty !== 1'b0) begin n_fail++;
         $display("FAIL single_empty got %b exp 0", regi_aclrxbufempty); end
      n_checks++; if (bsm_rxlen !== 10'd27) begin n_fail++;
         $display("FAIL single_rxlen got %0d exp 27", bsm_rxlen); end
      for (int i = 0; i < 7; i++) begin
         rd(8'(i), 1'b1);
         n_checks++; if (bsm_dout !== 32'hA000_0000 + 32'(i)) begin n_fail++;
            $display("FAIL single_dout[%0d] got %h exp %h", i, bsm_dout,
                     32'hA000_0000 + 32'(i)); end
         n_checks++; if (rxbuf_count !== ((i == 6) ? 3'd0 : 3'd1)) begin n_fail++;
            $display("FAIL single_drain_count[%0d] got %0d exp %0d", i, rxbuf_count,
                     (i == 6) ? 0 : 1); end
      end
      n_checks++; if (regi_aclrxbufempty !== 1'b1) begin n_fail++;
         $display("FAIL single_empty_after got %b exp 1", regi_aclrxbufempty); end
   endtask

   task automatic test_full();
      for (int k = 0; k < 4; k++) begin
         wr(8'd0, 32'hB0 + 32'(k));
         commit(10'd4);
      end
      n_checks++; if (rxbuf_count !== 3'd4) begin n_fail++;
         $display("FAIL full_count got %0d exp 4", rxbuf_count); end
      n_checks++; if (regi_aclrxbuffull !== 1'b1) begin n_fail++;
         $display("FAIL full_flag got %b exp 1", regi_aclrxbuffull); end
      wr(8'd0, 32'hDEAD);
      commit(10'd4);
      n_checks++; if (regi_aclrxovf !== 1'b1) begin n_fail++;
         $display("FAIL full_ovf_set got %b exp 1", regi_aclrxovf); end
      n_checks++; if (rxbuf_count !== 3'd4) begin n_fail++;
         $display("FAIL full_count_drop got %0d exp 4", rxbuf_count); end
      rd(8'd0, 1'b0);
      n_checks++; if (bsm_dout !== 32'hB0) begin n_fail++;
         $display("FAIL full_protect got %h exp b0", bsm_dout); end
      regi_ovf_clr = 1'b1; tick(); regi_ovf_clr = 1'b0;
      n_checks++; if (regi_aclrxovf !== 1'b0) begin n_fail++;
         $display("FAIL full_ovf_clr got %b exp 0", regi_aclrxovf); end
      for (int k = 0; k < 4; k++) begin
         rd(8'd0, 1'b1);
         n_checks++; if (bsm_dout !== 32'hB0 + 32'(k)) begin n_fail++;
            $display("FAIL full_drain_dout[%0d] got %h exp %h", k, bsm_dout,
                     32'hB0 + 32'(k)); end
         n_checks++; if (rxbuf_count !== 3'(3 - k)) begin n_fail++;
            $display("FAIL full_drain_count[%0d] got %0d exp %0d", k, rxbuf_count, 3 - k); end
      end
      n_checks++; if (regi_aclrxbuffull !== 1'b0) begin n_fail++;
         $display("FAIL full_flag_after got %b exp 0", regi_aclrxbuffull); end
   endtask

   task automatic test_lengths();
      logic [9:0] lens [4];
      int         ends [4];
      logic [31:0] exp_d;
      lens[0] = 10'd4; lens[1] = 10'd1; lens[2] = 10'd0; lens[3] = 10'd1023;
      ends[0] = 0; ends[1] = 0; ends[2] = 0; ends[3] = 255;
      for (int k = 0; k < 4; k++) begin
         wr(8'd0, 32'hC0 + 32'(k));
         if (k == 3) wr(8'd255, 32'hCFF);
         commit(lens[k]);
      end
      for (int k = 0; k < 4; k++) begin
         n_checks++; if (bsm_rxlen !== lens[k]) begin n_fail++;
            $display("FAIL len_rxlen[%0d] got %0d exp %0d", k, bsm_rxlen, lens[k]); end
         if (ends[k] > 0) begin
            rd(8'(ends[k] - 1), 1'b1);
            n_checks++; if (rxbuf_count !== 3'(4 - k)) begin n_fail++;
               $display("FAIL len_early_end[%0d] got %0d exp %0d", k, rxbuf_count, 4 - k); end
         end
         rd(8'(ends[k]), 1'b1);
         exp_d = (k == 3) ? 32'hCFF : 32'hC0 + 32'(k);
         n_checks++; if (bsm_dout !== exp_d) begin n_fail++;
            $display("FAIL len_dout[%0d] got %h exp %h", k, bsm_dout, exp_d); end
         n_checks++; if (rxbuf_count !== 3'(3 - k)) begin n_fail++;
            $display("FAIL len_end_count[%0d] got %0d exp %0d", k, rxbuf_count, 3 - k); end
      end
   endtask

   task automatic test_back_to_back();
      wr(8'd0, 32'hD1); commit(10'd4);
      wr(8'd0, 32'hD2); commit(10'd4);
      n_checks++; if (rxbuf_count !== 3'd2) begin n_fail++;
         $display("FAIL b2b_pre_count got %0d exp 2", rxbuf_count); end
      wr(8'd0, 32'hD3);
      ms_tslot_p = 1'b1; dec_hecgood = 1'b1; dec_crcgood = 1'b1; dec_pylenByte = 10'd4;
      bsm_cs = 1'b1; bsm_addr = 8'd0; bsm_valid_p = 1'b1;
      tick();
      ms_tslot_p = 1'b0; bsm_cs = 1'b0; bsm_valid_p = 1'b0;
      n_checks++; if (rxbuf_count !== 3'd2) begin n_fail++;
         $display("FAIL b2b_count1 got %0d exp 2", rxbuf_count); end
      n_checks++; if (bsm_dout !== 32'hD1) begin n_fail++;
         $display("FAIL b2b_dout1 got %h exp d1", bsm_dout); end
      wr(8'd0, 32'hD4);
      ms_tslot_p = 1'b1; bsm_cs = 1'b1; bsm_addr = 8'd0; bsm_valid_p = 1'b1;
      tick();
      ms_tslot_p = 1'b0; dec_hecgood = 1'b0; dec_crcgood = 1'b0;
      bsm_cs = 1'b0; bsm_valid_p = 1'b0;
      n_checks++; if (rxbuf_count !== 3'd2) begin n_fail++;
         $display("FAIL b2b_count2 got %0d exp 2", rxbuf_count); end
      n_checks++; if (bsm_dout !== 32'hD2) begin n_fail++;
         $display("FAIL b2b_dout2 got %h exp d2", bsm_dout); end
      rd(8'd0, 1'b1);
      n_checks++; if (bsm_dout !== 32'hD3) begin n_fail++;
         $display("FAIL b2b_dout3 got %h exp d3", bsm_dout); end
      rd(8'd0, 1'b1);
      n_checks++; if (bsm_dout !== 32'hD4) begin n_fail++;
         $display("FAIL b2b_wrap_dout got %h exp d4", bsm_dout); end
      n_checks++; if (rxbuf_count !== 3'd0) begin n_fail++;
         $display("FAIL b2b_final_count got %0d exp 0", rxbuf_count); end
   endtask

   task automatic bad_pkts(input logic [2:0] exp_cnt);
      for (int c = 0; c < 3; c++) begin
         ms_tslot_p = 1'b1; pk_encode = (c == 0);
         dec_hecgood = (c != 1); dec_crcgood = (c != 2); dec_pylenByte = 10'd4;
         tick();
         ms_tslot_p = 1'b0; pk_encode = 1'b0; dec_hecgood = 1'b0; dec_crcgood = 1'b0;
         n_checks++; if (rxbuf_count !== exp_cnt) begin n_fail++;
            $display("FAIL bad_count[%0d] got %0d exp %0d", c, rxbuf_count, exp_cnt); end
         n_checks++; if (regi_aclrxovf !== 1'b0) begin n_fail++;
            $display("FAIL bad_ovf[%0d] got %b exp 0", c, regi_aclrxovf); end
      end
   endtask

   task automatic test_bad_packets();
      bad_pkts(3'd0);
      for (int k = 0; k < 4; k++) commit(10'd4);
      bad_pkts(3'd4);
      for (int k = 0; k < 4; k++) rd(8'd0, 1'b1);
      n_checks++; if (rxbuf_count !== 3'd0) begin n_fail++;
         $display("FAIL bad_drain_count got %0d exp 0", rxbuf_count); end
   endtask

   task automatic test_flush_reset();
      for (int k = 0; k < 3; k++) begin
         wr(8'd0, 32'hF0 + 32'(k));
         commit(10'd4);
      end
      n_checks++; if (rxbuf_count !== 3'd3) begin n_fail++;
         $display("FAIL flush_pre_count got %0d exp 3", rxbuf_count); end
      regi_flush = 1'b1;
      ms_tslot_p = 1'b1; dec_hecgood = 1'b1; dec_crcgood = 1'b1; dec_pylenByte = 10'd4;
      tick();
      regi_flush = 1'b0; ms_tslot_p = 1'b0; dec_hecgood = 1'b0; dec_crcgood = 1'b0;
      n_checks++; if (rxbuf_count !== 3'd0) begin n_fail++;
         $display("FAIL flush_count got %0d exp 0", rxbuf_count); end
      n_checks++; if (regi_aclrxbufempty !== 1'b1) begin n_fail++;
         $display("FAIL flush_empty got %b exp 1", regi_aclrxbufempty); end
      n_checks++; if (regi_aclrxovf !== 1'b0) begin n_fail++;
         $display("FAIL flush_ovf got %b exp 0", regi_aclrxovf); end
      wr(8'd0, 32'hE0);
      commit(10'd4);
      rd(8'd0, 1'b0);
      n_checks++; if (bsm_dout !== 32'hE0) begin n_fail++;
         $display("FAIL flush_rptr_dout got %h exp e0", bsm_dout); end
      n_checks++; if (rxbuf_count !== 3'd1) begin n_fail++;
         $display("FAIL flush_new_count got %0d exp 1", rxbuf_count); end
      bsm_cs = 1'b1; bsm_addr = 8'd0;
      tick();
      #2 rstz = 1'b0;
      #1;
      test_reset();
      bsm_cs = 1'b0;
      #2 rstz = 1'b1;
      tick();
      n_checks++; if (rxbuf_count !== 3'd0) begin n_fail++;
         $display("FAIL post_reset_count got %0d exp 0", rxbuf_count); end
   endtask

   initial begin
      #12 rstz = 1'b1;
      tick();
      test_reset();
      test_single();
      test_full();
      test_lengths();
      test_back_to_back();
      test_bad_packets();
      test_flush_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
